coin_acceptor: RTL and testbench

//  Front end of the newspaper vending machine; sits directly upstream of the vending state machine.

---
 rtl/coin_acceptor_if.sv | 25 ++
 rtl/coin_acceptor.sv | 139 +++++++++++++
 tb/tb_coin_acceptor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensor and dispense strobe in, coin code and status out.
// Tally counters appear only when COIN_TALLY_EN is defined.
interface coin_acceptor_if;
  logic       sense;
  logic       newspaper;
  logic [1:0] coin;
  logic       reject;
  logic       jam;
`ifdef COIN_TALLY_EN
  logic [15:0] tally5;
  logic [15:0] tally10;

  modport master (output sense, output newspaper,
                  input coin, input reject, input jam,
                  input tally5, input tally10);
  modport slave  (input sense, input newspaper,
                  output coin, output reject, output jam,
                  output tally5, output tally10);
`else
  modport master (output sense, output newspaper,
                  input coin, input reject, input jam);
  modport slave  (input sense, input newspaper,
                  output coin, output reject, output jam);
`endif
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronise + debounce sensor, measure pulse width, classify coin, hold the
// code while a dispense is in progress. Optional COIN_TALLY_EN adds 16-bit per-coin tallies.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN5       = 8,
  parameter int MAX5       = 15,
  parameter int MIN10      = 20,
  parameter int MAX10      = 40,
  parameter int CNT_W      = 8
) (
  input logic          clock,
  input logic          reset,
  coin_acceptor_if.slave bus
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] W_MIN5   = CNT_W'(MIN5);
  localparam logic [CNT_W-1:0] W_MAX5   = CNT_W'(MAX5);
  localparam logic [CNT_W-1:0] W_MIN10  = CNT_W'(MIN10);
  localparam logic [CNT_W-1:0] W_MAX10  = CNT_W'(MAX10);
  localparam logic [CNT_W-1:0] W_SAT    = CNT_W'(MAX10 + 1);

  typedef enum logic [1:0] {IDLE, MEAS, EMIT, JAM} state_t;

  logic             sync1, sync2, fs;
  logic [DEB_W-1:0] deb_cnt;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [1:0]       code_q, code_d;
  logic             reject_q, reject_d;
  logic [1:0]       coin_d;

  // fs flips only after the synced input has disagreed with it for DEB_CYCLES straight cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      fs      <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= bus.sense;
      sync2 <= sync1;
      if (sync2 != fs) begin
        if (deb_cnt == DEB_LAST) begin
          fs      <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      width_q  <= '0;
      code_q   <= 2'b00;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      code_q   <= code_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    code_d   = code_q;
    reject_d = 1'b0;
    coin_d   = 2'b00;
    case (state_q)
      IDLE: begin
        if (fs) begin
          state_d = MEAS;
          width_d = CNT_W'(1);
        end
      end
      MEAS: begin
        if (fs) begin
          width_d = width_q + 1'b1;
          if (width_q == W_SAT - 1'b1) state_d = JAM;
        end else begin
          width_d = '0;
          if (width_q >= W_MIN5 && width_q <= W_MAX5) begin
            code_d  = 2'b01;
            state_d = EMIT;
          end else if (width_q >= W_MIN10 && width_q <= W_MAX10) begin
            code_d  = 2'b10;
            state_d = EMIT;
          end else begin
            reject_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      EMIT: begin
        // a dispense in progress holds the code back rather than dropping it
        coin_d = bus.newspaper ? 2'b00 : code_q;
        if (!bus.newspaper) state_d = IDLE;
      end
      JAM: begin
        if (!fs) begin
          state_d = IDLE;
          width_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.coin   = coin_d;
  assign bus.reject = reject_q;
  assign bus.jam    = (state_q == JAM);

`ifdef COIN_TALLY_EN
  logic [15:0] tally5_q, tally10_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      tally5_q  <= '0;
      tally10_q <= '0;
    end else begin
      if (coin_d == 2'b01) tally5_q  <= tally5_q + 1'b1;
      if (coin_d == 2'b10) tally10_q <= tally10_q + 1'b1;
    end
  end

  assign bus.tally5  = tally5_q;
  assign bus.tally10 = tally10_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed edge cases then random coins against a width-rule model.
module tb_coin_acceptor;
  localparam int DEB = 4;
  localparam int MIN5 = 8, MAX5 = 15, MIN10 = 20, MAX10 = 40;
  localparam int EMIT_K = 2 + DEB + 1;
  localparam int WIN = 16;

  logic clock = 1'b0;
  logic reset;
  coin_acceptor_if bus();

  coin_acceptor dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int exp_t5 = 0;
  int exp_t10 = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tally(input string tag);
`ifdef COIN_TALLY_EN
    check({tag, "_tally5"}, int'(bus.tally5), exp_t5 % 65536);
    check({tag, "_tally10"}, int'(bus.tally10), exp_t10 % 65536);
`endif
  endtask

  // Drive a clean n-cycle sensor pulse, hold newspaper for h cycles from when a code could
  // first appear, then compare what was seen with the width classification rules.
  task automatic run_coin(input int n, input int h);
    int coin_cnt = 0, coin_val = 0, coin_k = -1;
    int rej_cnt = 0, rej_k = -1, jam_seen = 0, overlap = 0;
    int exp_code, exp_rej, exp_jam;
    string tag;
    tag = $sformatf("w%0d_h%0d", n, h);

    bus.sense = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      if (bus.coin != 2'b00) coin_cnt++;
      if (bus.reject) rej_cnt++;
      if (bus.jam) jam_seen = 1;
    end
    bus.sense = 1'b0;
    for (int k = 1; k <= WIN; k++) begin
      @(posedge clock); #1;
      bus.newspaper = (k >= EMIT_K && k < EMIT_K + h);
      #1;
      if (bus.coin != 2'b00) begin
        coin_cnt++;
        coin_val = int'(bus.coin);
        coin_k = k;
      end
      if (bus.reject) begin
        rej_cnt++;
        rej_k = k;
      end
      if (bus.reject && bus.coin != 2'b00) overlap++;
      if (bus.jam) jam_seen = 1;
    end
    bus.newspaper = 1'b0;

    if (n < DEB)                        exp_code = 0;
    else if (n >= MIN5 && n <= MAX5)    exp_code = 1;
    else if (n >= MIN10 && n <= MAX10)  exp_code = 2;
    else                                exp_code = 0;
    exp_jam = (n > MAX10) ? 1 : 0;
    exp_rej = (n >= DEB && exp_code == 0 && exp_jam == 0) ? 1 : 0;
    if (exp_code == 1) exp_t5++;
    if (exp_code == 2) exp_t10++;

    check({tag, "_coin_cnt"}, coin_cnt, (exp_code != 0) ? 1 : 0);
    if (exp_code != 0) begin
      check({tag, "_coin_val"}, coin_val, exp_code);
      check({tag, "_coin_cycle"}, coin_k, EMIT_K + h);
    end
    check({tag, "_reject_cnt"}, rej_cnt, exp_rej);
    if (exp_rej != 0) check({tag, "_reject_cycle"}, rej_k, EMIT_K);
    check({tag, "_jam_seen"}, jam_seen, exp_jam);
    check({tag, "_jam_final"}, int'(bus.jam), 0);
    check({tag, "_overlap"}, overlap, 0);
    check_tally(tag);
  endtask

  int dir_n [16] = '{10, 30, 5, 17, 45, 7, 8, 15, 16, 40, 41, 2, 3, 4, 10, 30};
  int dir_h [16] = '{ 0,  0, 0,  0,  0, 0, 0,  0,  0,  0,  0, 0, 0, 0,  1,  3};

  initial begin
    int stray;
    reset = 1'b1;
    bus.sense = 1'b0;
    bus.newspaper = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_coin", int'(bus.coin), 0);
    check("reset_reject", int'(bus.reject), 0);
    check("reset_jam", int'(bus.jam), 0);
    check_tally("reset");
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < 16; i++) run_coin(dir_n[i], dir_h[i]);

    // reset lands while a pulse has been measured to width 12
    bus.sense = 1'b1;
    repeat (18) @(posedge clock);
    #1;
    reset = 1'b1;
    bus.sense = 1'b0;
    @(posedge clock); #1;
    exp_t5 = 0;
    exp_t10 = 0;
    check("midreset_coin", int'(bus.coin), 0);
    check("midreset_reject", int'(bus.reject), 0);
    check("midreset_jam", int'(bus.jam), 0);
    check_tally("midreset");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < WIN; k++) begin
      @(posedge clock); #1;
      if (bus.coin != 2'b00 || bus.reject || bus.jam) stray++;
    end
    check("postreset_quiet", stray, 0);
    run_coin(12, 0);

    for (int i = 0; i < 24; i++) run_coin($urandom_range(1, 50), $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
